udm_bus_arbiter: RTL

UDM_BUS_ARBITER -- requirements
Module: udm_bus_arbiter

---
 rtl/udm_pkg.sv | 28 ++
 rtl/udm_arb_wdt.sv | 29 ++
 rtl/udm_bus_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/udm_pkg.sv
// Shared definitions for the udm bus arbiter: FSM state encoding, master indices,
// the default watchdog read-data pattern and the round-robin pick helper.
package udm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } udm_arb_state_e;

    localparam logic        UDM_M0           = 1'b0;
    localparam logic        UDM_M1           = 1'b1;
    localparam logic [31:0] UDM_TIMEOUT_DATA = 32'hDEADBEEF;

    // On a tie the master that was not served last wins; a lone requester always wins.
    function automatic logic udm_rr_pick(input logic req0, input logic req1, input logic last);
        logic pick;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = UDM_M1;
        end else begin
            pick = UDM_M0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/udm_arb_wdt.sv
// Watchdog counter for the udm bus arbiter; only instantiated when
// UDM_BUS_ARB_TIMEOUT_EN is defined. expire_o is high on the TIMEOUT-th cycle after a clear.
module udm_arb_wdt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int           CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Saturating cycle counter, cleared whenever the arbiter changes phase.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/udm_bus_arbiter.sv
// Round-robin arbiter between the udm debug master (m0) and the CPU (m1) onto one slave
// bus. Define UDM_BUS_ARB_TIMEOUT_EN to build in the watchdog abort path (udm_arb_wdt).
module udm_bus_arbiter
    import udm_pkg::*;
#(
    parameter int          TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_DATA = UDM_TIMEOUT_DATA
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_ack_o,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,
    input  logic        m1_req_i,
    output logic        m1_ack_o,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,
    output logic        bus_req_o,
    input  logic        bus_ack_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_bo,
    output logic [3:0]  bus_be_bo,
    output logic [31:0] bus_wdata_bo,
    input  logic        bus_resp_i,
    input  logic [31:0] bus_rdata_bi,
    output logic        grant_o,
    output logic        busy_o,
    output logic        err_o
);
    udm_arb_state_e state_q;
    logic           grant_q;
    logic           last_q;
    logic           abort_q;

    logic           g_req_s;
    logic           g_we_s;
    logic [31:0]    g_addr_s;
    logic [3:0]     g_be_s;
    logic [31:0]    g_wdata_s;
    logic           pick_s;
    logic           in_req_s;
    logic           in_resp_s;
    logic           expire_s;
    logic           drop_s;
    logic           abort_req_s;
    logic           ack_fire_s;
    logic           resp_to_s;
    logic           resp_fire_s;
    logic           tdata_s;
    logic           m_ack_s;
    logic           err_s;
    logic           active_s;

    assign g_req_s   = (grant_q == UDM_M1) ? m1_req_i    : m0_req_i;
    assign g_we_s    = (grant_q == UDM_M1) ? m1_we_i     : m0_we_i;
    assign g_addr_s  = (grant_q == UDM_M1) ? m1_addr_bi  : m0_addr_bi;
    assign g_be_s    = (grant_q == UDM_M1) ? m1_be_bi    : m0_be_bi;
    assign g_wdata_s = (grant_q == UDM_M1) ? m1_wdata_bi : m0_wdata_bi;
    assign pick_s    = udm_rr_pick(m0_req_i, m1_req_i, last_q);

    assign in_req_s  = (state_q == ST_REQ);
    assign in_resp_s = (state_q == ST_RESP);

    // A dropped request wins over everything; an expiry withdraws bus_req so a late ack is moot.
    assign drop_s      = in_req_s & ~g_req_s;
    assign abort_req_s = in_req_s & g_req_s & expire_s;
    assign ack_fire_s  = in_req_s & g_req_s & ~expire_s & bus_ack_i;
    assign resp_to_s   = in_resp_s & ~abort_q & ~bus_resp_i & expire_s;
    assign resp_fire_s = (in_resp_s & (abort_q | bus_resp_i)) | resp_to_s;
    assign tdata_s     = in_resp_s & (abort_q | (~bus_resp_i & expire_s));
    assign m_ack_s     = ack_fire_s | abort_req_s;
    assign err_s       = abort_req_s | resp_to_s;

`ifdef UDM_BUS_ARB_TIMEOUT_EN
    logic leave_s;
    logic wdt_clr_s;

    assign leave_s   = drop_s | m_ack_s | resp_fire_s;
    assign wdt_clr_s = (state_q == ST_IDLE) | leave_s;

    udm_arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wdt_clr_s),
        .expire_o (expire_s)
    );
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 0);
    assign expire_s         = 1'b0;
`endif

    // Arbitration FSM: owner, last-served pointer and transaction phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= UDM_M0;
            last_q  <= UDM_M1;
            abort_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        grant_q <= pick_s;
                        last_q  <= pick_s;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (drop_s) begin
                        state_q <= ST_IDLE;
                    end else if (m_ack_s) begin
                        state_q <= g_we_s ? ST_IDLE : ST_RESP;
                        abort_q <= abort_req_s & ~g_we_s;
                    end
                end
                ST_RESP: begin
                    if (resp_fire_s) begin
                        state_q <= ST_IDLE;
                        abort_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    abort_q <= 1'b0;
                end
            endcase
        end
    end

    // Everything is forced low while reset is asserted so an interrupted transfer never pulses.
    assign active_s     = ~rst_i;
    assign bus_req_o    = active_s & g_req_s & in_req_s & ~expire_s;
    assign bus_we_o     = active_s & in_req_s & g_we_s;
    assign bus_addr_bo  = (active_s & in_req_s) ? g_addr_s  : 32'h0000_0000;
    assign bus_be_bo    = (active_s & in_req_s) ? g_be_s    : 4'h0;
    assign bus_wdata_bo = (active_s & in_req_s) ? g_wdata_s : 32'h0000_0000;

    assign m0_ack_o    = active_s & m_ack_s & (grant_q == UDM_M0);
    assign m1_ack_o    = active_s & m_ack_s & (grant_q == UDM_M1);
    assign m0_resp_o   = active_s & resp_fire_s & (grant_q == UDM_M0);
    assign m1_resp_o   = active_s & resp_fire_s & (grant_q == UDM_M1);
    assign m0_rdata_bo = ~active_s ? 32'h0000_0000 : (tdata_s ? TIMEOUT_DATA : bus_rdata_bi);
    assign m1_rdata_bo = ~active_s ? 32'h0000_0000 : (tdata_s ? TIMEOUT_DATA : bus_rdata_bi);

    assign grant_o = active_s & grant_q;
    assign busy_o  = active_s & (in_req_s | in_resp_s);
    assign err_o   = active_s & err_s;

endmodule
